// File: rtl/pilha_dados_pkg.sv
// -----------------------------------------------------------------------------
// pilha_dados_pkg
// Shared stack-processor definitions: stack command encodings (also used by
// the control unit), default data-stack geometry and the stack FSM states.
// -----------------------------------------------------------------------------
package pilha_dados_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int DEPTH_DEF = 32;

    // Command codes on the control unit's stack interface.
    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_PUSH  = 2'b01,
        CMD_POP   = 2'b10,
        CMD_REPL2 = 2'b11   // pop two operands, push the ALU result
    } cmd_e;

    // RUN executes commands; HALT is entered on an illegal command and is
    // left only through reset.
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

endpackage

// File: rtl/pilha_dados_stack_ctl.sv
// -----------------------------------------------------------------------------
// pilha_dados_stack_ctl
// Stack pointer, RUN/HALT FSM and command legality checks for the data stack.
// Kept apart from the storage array so the array can move to block RAM.
//
// Ports:
//   clock   in   system clock, posedge
//   reset   in   synchronous, active-high
//   cmd     in   stack command (cmd_e encoding)
//   wr_en   out  write data_in into the array this edge
//   wr_addr out  array slot written when wr_en is high
//   sp      out  registered stack pointer == number of valid entries
//   ovf     out  sticky overflow flag
//   unf     out  sticky underflow flag
//   halted  out  stack has stopped after an illegal command
// -----------------------------------------------------------------------------
module pilha_dados_stack_ctl
    import pilha_dados_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [1:0]    cmd,
    output logic          wr_en,
    output logic [PW-1:0] wr_addr,
    output logic [PW:0]   sp,
    output logic          ovf,
    output logic          unf,
    output logic          halted
);

    localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);
    localparam logic [PW:0] ONE_W   = (PW+1)'(1);
    localparam logic [PW:0] TWO_W   = (PW+1)'(2);

    cmd_e        cmd_op;
    state_e      state_q, state_d;
    logic [PW:0] sp_q, sp_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;

    assign cmd_op = cmd_e'(cmd);

    // Legality is judged on the depth before the edge. An illegal command
    // leaves sp untouched, so sp can never wrap.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a latch behind.
        state_d = state_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        wr_en   = 1'b0;
        wr_addr = sp_q[PW-1:0];

        if (state_q == RUN && !reset) begin
            case (cmd_op)
                CMD_PUSH: begin
                    if (sp_q < DEPTH_W) begin
                        wr_en = 1'b1;
                        sp_d  = sp_q + ONE_W;
                    end else begin
                        ovf_d   = 1'b1;
                        state_d = HALT;
                    end
                end
                CMD_POP: begin
                    if (sp_q != '0) begin
                        sp_d = sp_q - ONE_W;
                    end else begin
                        unf_d   = 1'b1;
                        state_d = HALT;
                    end
                end
                CMD_REPL2: begin
                    // The result overwrites the lower operand (sp-2); the
                    // upper operand slot becomes free.
                    if (sp_q >= TWO_W) begin
                        wr_en   = 1'b1;
                        wr_addr = sp_q[PW-1:0] - PW'(2);
                        sp_d    = sp_q - ONE_W;
                    end else begin
                        unf_d   = 1'b1;
                        state_d = HALT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (reset) begin
            state_q <= RUN;
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign sp     = sp_q;
    assign ovf    = ovf_q;
    assign unf    = unf_q;
    assign halted = (state_q == HALT);

endmodule

// File: rtl/pilha_dados.sv
// -----------------------------------------------------------------------------
// pilha_dados
// Data stack of the stack processor. Services PUSH / POP / REPL2 from the
// control unit, presents the top two entries combinationally, and latches a
// sticky error and halts on overflow or underflow.
//
// Ports:
//   clock    in   system clock, posedge
//   reset    in   synchronous, active-high; empties the stack, clears errors
//   cmd      in   00 NOP, 01 PUSH, 10 POP, 11 REPL2
//   data_in  in   word for PUSH / REPL2
//   top      out  entry at sp-1, 0 when empty
//   next     out  entry at sp-2, 0 when depth < 2
//   depth    out  number of valid entries, 0..DEPTH
//   empty    out  depth == 0
//   full     out  depth == DEPTH
//   ovf      out  sticky overflow
//   unf      out  sticky underflow
//   halted   out  ovf | unf; commands are ignored while high
// -----------------------------------------------------------------------------
module pilha_dados
    import pilha_dados_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       cmd,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] next,
    output logic [PW:0]      depth,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf,
    output logic             halted
);

    localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);
    localparam logic [PW:0] TWO_W   = (PW+1)'(2);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en;
    logic [PW-1:0]    wr_addr;
    logic [PW:0]      sp;
    logic [PW-1:0]    top_idx;
    logic [PW-1:0]    next_idx;

    pilha_dados_stack_ctl #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_ctl (
        .clock   (clock),
        .reset   (reset),
        .cmd     (cmd),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .sp      (sp),
        .ovf     (ovf),
        .unf     (unf),
        .halted  (halted)
    );

    // NOTE: the storage array has no reset; stale words are never visible
    // because top/next are masked by sp, and leaving it unreset lets it map
    // onto RAM later.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= data_in;
        end
    end

    // Modulo-DEPTH index arithmetic: at sp == DEPTH the low bits are 0 and
    // subtracting 1 lands on DEPTH-1, as intended.
    assign top_idx  = sp[PW-1:0] - PW'(1);
    assign next_idx = sp[PW-1:0] - PW'(2);

    assign top   = (sp != '0)    ? mem_q[top_idx]  : '0;
    assign next  = (sp >= TWO_W) ? mem_q[next_idx] : '0;
    assign depth = sp;
    assign empty = (sp == '0);
    assign full  = (sp == DEPTH_W);

endmodule

// File: tb/tb_pilha_dados.sv
// -----------------------------------------------------------------------------
// tb_pilha_dados
// Self-checking bench for pilha_dados: directed scenarios followed by
// randomized command streams, compared against a queue-based stack model.
// -----------------------------------------------------------------------------
module tb_pilha_dados;
    import pilha_dados_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 32;
    localparam int PW    = $clog2(DEPTH);

    logic             clock;
    logic             reset;
    logic [1:0]       cmd;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] next;
    logic [PW:0]      depth;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;
    logic             halted;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a queue whose back is the top of stack.
    logic [WIDTH-1:0] m_q[$];
    bit               m_ovf;
    bit               m_unf;

    pilha_dados #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .cmd     (cmd),
        .data_in (data_in),
        .top     (top),
        .next    (next),
        .depth   (depth),
        .empty   (empty),
        .full    (full),
        .ovf     (ovf),
        .unf     (unf),
        .halted  (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic [1:0] c, input logic [WIDTH-1:0] d);
        if (r) begin
            m_q.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (!(m_ovf || m_unf)) begin
            case (c)
                CMD_PUSH:  if (m_q.size() < DEPTH) m_q.push_back(d); else m_ovf = 1;
                CMD_POP:   if (m_q.size() >= 1) void'(m_q.pop_back()); else m_unf = 1;
                CMD_REPL2: begin
                    if (m_q.size() >= 2) begin
                        void'(m_q.pop_back());
                        void'(m_q.pop_back());
                        m_q.push_back(d);
                    end else begin
                        m_unf = 1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all(input string tag);
        int               n;
        logic [WIDTH-1:0] e_top;
        logic [WIDTH-1:0] e_next;
        n      = m_q.size();
        e_top  = (n >= 1) ? m_q[n-1] : '0;
        e_next = (n >= 2) ? m_q[n-2] : '0;
        check({tag, ".depth"},  32'(depth),  32'(n));
        check({tag, ".top"},    32'(top),    32'(e_top));
        check({tag, ".next"},   32'(next),   32'(e_next));
        check({tag, ".empty"},  32'(empty),  32'(n == 0));
        check({tag, ".full"},   32'(full),   32'(n == DEPTH));
        check({tag, ".ovf"},    32'(ovf),    32'(m_ovf));
        check({tag, ".unf"},    32'(unf),    32'(m_unf));
        check({tag, ".halted"}, 32'(halted), 32'(m_ovf || m_unf));
    endtask

    // One clock: drive inputs, take the edge, update the model, sample #1 later.
    task automatic step(input string tag, input logic r, input logic [1:0] c,
                        input logic [WIDTH-1:0] d);
        reset   = r;
        cmd     = c;
        data_in = d;
        @(posedge clock);
        model_update(r, c, d);
        #1;
        compare_all(tag);
    endtask

    initial begin
        int r;
        int push_pct;
        logic [1:0] c;
        logic [WIDTH-1:0] d;

        reset   = 1'b1;
        cmd     = CMD_NOP;
        data_in = '0;
        m_ovf   = 0;
        m_unf   = 0;

        // Reset values.
        step("rst", 1'b1, CMD_NOP, 16'h0000);
        check("rst_depth_const", 32'(depth), 32'd0);
        check("rst_empty_const", 32'(empty), 32'd1);

        // Two pushes then a pop.
        step("p11", 1'b0, CMD_PUSH, 16'h0011);
        step("p22", 1'b0, CMD_PUSH, 16'h0022);
        check("tp1_top",  32'(top),  32'h0022);
        check("tp1_next", 32'(next), 32'h0011);
        step("pop1", 1'b0, CMD_POP, 16'h0000);
        check("tp1_pop_top",   32'(top),   32'h0011);
        check("tp1_pop_next",  32'(next),  32'h0000);
        check("tp1_pop_depth", 32'(depth), 32'd1);

        // REPL2 as an ALU sum.
        step("rst2", 1'b1, CMD_NOP, 16'h0000);
        step("p5", 1'b0, CMD_PUSH, 16'h0005);
        step("p3", 1'b0, CMD_PUSH, 16'h0003);
        step("repl", 1'b0, CMD_REPL2, 16'h0008);
        check("tp2_top",   32'(top),   32'h0008);
        check("tp2_depth", 32'(depth), 32'd1);

        // Fill, overflow, ignored POP while halted.
        step("rst3", 1'b1, CMD_NOP, 16'h0000);
        for (int i = 1; i <= DEPTH; i++) step("fill", 1'b0, CMD_PUSH, WIDTH'(i));
        check("tp3_full", 32'(full), 32'd1);
        check("tp3_top",  32'(top),  32'd32);
        step("ovf", 1'b0, CMD_PUSH, 16'd33);
        check("tp3_ovf",    32'(ovf),    32'd1);
        check("tp3_halted", 32'(halted), 32'd1);
        check("tp3_top2",   32'(top),    32'd32);
        step("pop_halted", 1'b0, CMD_POP, 16'h0000);
        check("tp3_depth", 32'(depth), 32'd32);

        // Reset wins over PUSH on the same edge while halted.
        step("rst_push", 1'b1, CMD_PUSH, 16'h0077);
        check("tp5_depth", 32'(depth), 32'd0);
        check("tp5_ovf",   32'(ovf),   32'd0);
        step("pAA", 1'b0, CMD_PUSH, 16'h00AA);
        check("tp5_top", 32'(top), 32'h00AA);

        // Underflow on POP when empty.
        step("rst4", 1'b1, CMD_NOP, 16'h0000);
        step("unf_pop", 1'b0, CMD_POP, 16'h0000);
        check("tp4_unf", 32'(unf), 32'd1);

        // Underflow on REPL2 with depth 1; top unchanged.
        step("rst5", 1'b1, CMD_NOP, 16'h0000);
        step("p7", 1'b0, CMD_PUSH, 16'h0007);
        step("unf_repl", 1'b0, CMD_REPL2, 16'h1234);
        check("tp4_repl_unf", 32'(unf), 32'd1);
        check("tp4_repl_top", 32'(top), 32'h0007);

        // Alternating PUSH/POP for 20 cycles.
        step("rst6", 1'b1, CMD_NOP, 16'h0000);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) step("alt_push", 1'b0, CMD_PUSH, WIDTH'($urandom));
            else            step("alt_pop",  1'b0, CMD_POP,  16'h0000);
        end

        // Randomized streams; push bias flips every 100 cycles so the stack
        // swings between empty and full.
        step("rst7", 1'b1, CMD_NOP, 16'h0000);
        for (int i = 0; i < 4000; i++) begin
            push_pct = ((i / 100) % 2 == 0) ? 70 : 25;
            r = $urandom_range(99);
            d = WIDTH'($urandom);
            if (r < 10)                 c = CMD_NOP;
            else if (r < 10 + push_pct) c = CMD_PUSH;
            else if (r < 85)            c = CMD_POP;
            else                        c = CMD_REPL2;
            step("rand", ($urandom_range(99) < 2), c, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
